// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types for the sequencing matrix load/store unit
package datapath_pkg;

    typedef enum logic [1:0] {
        NOP     = 2'b00,
        LOAD    = 2'b01,
        STORE   = 2'b10,
        ILLEGAL = 2'b11
    } matls_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } matls_state_t;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_ROW_W  = 2;

    // Request bundle as seen by the scratchpad arbiter at default widths.
    typedef struct packed {
        matls_op_t             ls;
        logic [DEF_REG_W-1:0]  reg_idx;
        logic [DEF_ROW_W-1:0]  row;
        logic [DEF_ADDR_W-1:0] addr;
    } matls_req_t;

endpackage

// File: rtl/fu_matrix_ls_seq_if.sv
// rtl/fu_matrix_ls_seq_if.sv - signal bundle between matrix issue/scratchpad and the LS unit
interface fu_matrix_ls_seq_if #(
    parameter int ADDR_W = 11,
    parameter int ROWS   = 4,
    parameter int REG_W  = 5,
    parameter int WORD_W = 32,
    parameter int IMM_W  = 11,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input logic clk
);
    logic              rst;
    logic              enable;
    logic [1:0]        ls_in;
    logic [REG_W-1:0]  rd_in;
    logic [WORD_W-1:0] rs_in;
    logic [WORD_W-1:0] stride_in;
    logic [IMM_W-1:0]  imm_in;
    logic              flush;
    logic              ready_out;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_ls;
    logic [REG_W-1:0]  req_reg;
    logic [ROW_W-1:0]  req_row;
    logic [ADDR_W-1:0] req_addr;
    logic              busy;
    logic              done;
    logic              err;

    modport fu (
        input  clk, rst, enable, ls_in, rd_in, rs_in, stride_in, imm_in, flush, req_ready,
        output ready_out, req_valid, req_ls, req_reg, req_row, req_addr, busy, done, err
    );

    modport tb (
        input  clk, ready_out, req_valid, req_ls, req_reg, req_row, req_addr, busy, done, err,
        output rst, enable, ls_in, rd_in, rs_in, stride_in, imm_in, flush, req_ready
    );
endinterface

// File: rtl/fu_matrix_ls_agen.sv
// rtl/fu_matrix_ls_agen.sv - row counter and running base+row*stride address accumulator
module fu_matrix_ls_agen #(
    parameter int ADDR_W = 11,
    parameter int ROWS   = 4,
    parameter int ROW_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr,
    output logic [ROW_W-1:0]  row,
    output logic              last
);
    logic [ADDR_W-1:0] stride_q;

    // Adding the stride once per accepted row avoids a row*stride multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            row      <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr     <= base;
            row      <= '0;
            stride_q <= stride;
        end else if (step) begin
            addr <= addr + stride_q;
            row  <= row + ROW_W'(1);
        end
    end

    assign last = (row == ROW_W'(ROWS - 1));

endmodule

// File: rtl/fu_matrix_ls_seq.sv
// rtl/fu_matrix_ls_seq.sv - sequencing matrix load/store unit, one scratchpad request per row
module fu_matrix_ls_seq
    import datapath_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int ROWS   = 4,
    parameter int REG_W  = 5,
    parameter int WORD_W = 32,
    parameter int IMM_W  = 11,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic [1:0]        ls_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [WORD_W-1:0] rs_in,
    input  logic [WORD_W-1:0] stride_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic              flush,
    output logic              ready_out,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [1:0]        req_ls,
    output logic [REG_W-1:0]  req_reg,
    output logic [ROW_W-1:0]  req_row,
    output logic [ADDR_W-1:0] req_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    matls_state_t      state_q, state_d;
    logic [1:0]        ls_q;
    logic [REG_W-1:0]  reg_q;
    logic              err_q;
    logic              op_ok;
    logic              agen_load;
    logic              agen_step;
    logic              agen_last;
    logic [ADDR_W-1:0] base;
    logic              unused_hi;

    assign op_ok     = (ls_in == LOAD) || (ls_in == STORE);
    assign base      = rs_in[ADDR_W-1:0] + ADDR_W'(imm_in);
    assign unused_hi = ^{rs_in[WORD_W-1:ADDR_W], stride_in[WORD_W-1:ADDR_W]};

    always_comb begin
        state_d   = state_q;
        agen_load = 1'b0;
        agen_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && op_ok) begin
                    agen_load = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                agen_step = req_ready && !agen_last;
                // Flush wins over a coinciding last-row handshake: no done for aborted ops.
                if (flush) begin
                    state_d = IDLE;
                end else if (req_ready && agen_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ls_q    <= '0;
            reg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && enable && (ls_in == ILLEGAL);
            if (agen_load) begin
                ls_q  <= ls_in;
                reg_q <= rd_in;
            end
        end
    end

    fu_matrix_ls_agen #(
        .ADDR_W (ADDR_W),
        .ROWS   (ROWS),
        .ROW_W  (ROW_W)
    ) u_agen (
        .clk    (CLK),
        .rst    (RST),
        .load   (agen_load),
        .step   (agen_step),
        .base   (base),
        .stride (stride_in[ADDR_W-1:0]),
        .addr   (req_addr),
        .row    (req_row),
        .last   (agen_last)
    );

    assign ready_out = (state_q == IDLE);
    assign busy      = (state_q == ISSUE);
    assign req_valid = (state_q == ISSUE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign req_ls    = ls_q;
    assign req_reg   = reg_q;

endmodule

// File: doc/fu_matrix_ls_seq.md
Name: fu_matrix_ls_seq

Overview:
Parametrised sequencing matrix load/store functional unit. It accepts one matrix LOAD or STORE per handshake and latches the operands. It then issues one scratchpad request per matrix row: address = base + row*stride, with a valid/ready handshake to the scratchpad. It pulses done when the last row request is accepted. The block sits between matrix issue and the scratchpad arbiter, and it replaces the single-shot, combinational LS unit.

Parameters:
ADDR_W, 11, scratchpad address width; addresses wrap modulo 2^ADDR_W
ROWS, 4, rows per matrix = requests per operation (>=1)
REG_W, 5, matrix register index width
WORD_W, 32, width of rs_in and stride_in
IMM_W, 11, immediate width (zero-extended)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
enable  in  1  operation request from issue
ls_in  in  2  2'b01 LOAD, 2'b10 STORE, 2'b00/2'b11 no-op/illegal
rd_in  in  REG_W  matrix register (LOAD destination / STORE source)
rs_in  in  WORD_W  scalar base register value
stride_in  in  WORD_W  row stride in address units
imm_in  in  IMM_W  address offset
flush  in  1  abort current operation
ready_out  out  1  unit idle, will accept enable next edge
req_valid  out  1  scratchpad request valid
req_ready  in  1  scratchpad accepts request (former mhit)
req_ls  out  2  latched op type
req_reg  out  REG_W  latched matrix register
req_row  out  $clog2(ROWS) (min 1)  row index of current request
req_addr  out  ADDR_W  row address
busy  out  1  operation in flight
done  out  1  one-cycle pulse, operation complete
err  out  1  one-cycle pulse, illegal ls_in accepted

Behaviour:
- Reset (sync, RST=1 at edge): state IDLE, ready_out=1, all other outputs 0, row counter 0. Overrides everything, including mid-operation; no done is issued.
- State IDLE:
  - ready_out=1.
  - Accept on edge when enable=1.
  - ls_in 01/10: latch ls, rd, stride[ADDR_W-1:0]; base = rs_in[ADDR_W-1:0] + zext(imm_in), truncated to ADDR_W; row=0; go ISSUE.
  - ls_in 11: err=1 next cycle, stay IDLE.
  - ls_in 00: ignored.
- State ISSUE:
  - busy=1, ready_out=0, req_valid=1.
  - req_addr = base + row*stride (mod 2^ADDR_W), maintained as a running accumulator, no multiplier.
  - req_addr, req_row, req_ls and req_reg are stable while req_valid=1 and req_ready=0.
  - Handshake when req_valid & req_ready at edge. If row<ROWS-1: row+1, addr+=stride. If row==ROWS-1: go DONE.
- State DONE: done=1 for exactly one cycle, busy=0, req_valid=0, ready_out=0; next state IDLE.
- Latency: first req_valid is 1 cycle after accept. With req_ready held 1, done asserts ROWS+1 cycles after accept, and the next op can be accepted at ROWS+2.
- flush: in ISSUE, go IDLE next edge with no done. If flush coincides with a handshake, that request counts as issued but the op still aborts. flush in IDLE or DONE has no effect (done still pulses).
- enable while not IDLE is ignored (issue must wait for ready_out).
- stride=0: all rows use the same address (legal).
- Address overflow wraps silently.
- ROWS=1: a single request, then DONE.

Decomposition:
- Shared package (datapath_pkg): matls_op_t enum (NOP=00, LOAD=01, STORE=10, ILLEGAL=11), matls_state_t (IDLE, ISSUE, DONE), and a matls_req_t struct {ls, reg, row, addr}.
- Sub-module fu_matrix_ls_agen: holds the base/stride accumulator and row counter, with load/step/last outputs.
- Top: FSM and handshake, using an interface fu_matrix_ls_seq_if with fu/tb modports.

Test Plan:
1. LOAD, rd=15, rs=100, imm=20, stride=5, req_ready=1 -> req_addr 120,125,130,135 on rows 0..3 in consecutive cycles; done exactly at cycle 5 after accept; req_reg=15, req_ls=01.
2. STORE, rd=25, rs=200, imm=30, stride=3, req_ready low for 2 cycles on row 1 -> row1 addr 233 held stable, req_valid held; addrs 230,233,236,239; done once.
3. Wrap: rs=2040, imm=0, stride=4, ADDR_W=11 -> addrs 2040,2044,0,4.
4. ls_in=11 with enable -> err pulse 1 cycle; no req_valid; ready_out stays 1. ls_in=00 -> no response.
5. flush asserted during row 2 -> IDLE next cycle, no done, ready_out=1; enable during ISSUE ignored (latched rd unchanged).
6. RST asserted mid-ISSUE -> all outputs 0 and ready_out=1 next cycle; stride=0 op afterward -> four identical addrs, done pulses.
